// File: rtl/servo_cmd_scheduler_if.sv
// Valid/ready command channel carrying left/right servo target codes
// from the line-follow decision logic into the servo scheduler.
interface servo_cmd_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_L;
   logic [7:0] cmd_R;

   modport master (output cmd_valid, output cmd_L, output cmd_R, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_L, input cmd_R, output cmd_ready);
endinterface

// File: rtl/servo_cmd_scheduler.sv
// Frame-synchronous servo command scheduler: one-deep command buffer, per-frame
// slew limiting, and a frame watchdog that ramps both servos back to neutral.
module servo_cmd_scheduler #(
   parameter int unsigned FRAME_CYCLES   = 1_000_002,
   parameter int unsigned NEUTRAL        = 150,
   parameter int unsigned MIN_POS        = 100,
   parameter int unsigned MAX_POS        = 200,
   parameter int unsigned MAX_STEP       = 4,
   parameter int unsigned TIMEOUT_FRAMES = 25
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   servo_cmd_scheduler_if.slave  cmd,
   output logic [7:0]            servo_L,
   output logic [7:0]            servo_R,
   output logic                  frame_tick,
   output logic                  failsafe,
   output logic                  busy
);
   localparam int unsigned CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_FRAMES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT_C = CNT_W'(FRAME_CYCLES - 1);
   localparam logic [WD_W-1:0]  WD_MAX_C   = WD_W'(TIMEOUT_FRAMES);
   localparam logic [7:0]       NEUTRAL_C  = 8'(NEUTRAL);
   localparam logic [7:0]       MIN_C      = 8'(MIN_POS);
   localparam logic [7:0]       MAX_C      = 8'(MAX_POS);
   localparam logic [7:0]       STEP_C     = 8'(MAX_STEP);
   localparam logic signed [8:0] STEP_S    = 9'(MAX_STEP);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRACK    = 2'd1,
      ST_FAILSAFE = 2'd2
   } state_t;

   state_t            state_r, state_s;
   logic [CNT_W-1:0]  frame_cnt_r, frame_cnt_s;
   logic              frame_tick_r;
   logic [7:0]        servo_left_r, servo_left_s, servo_right_r, servo_right_s;
   logic [7:0]        tgt_left_r, tgt_left_s, tgt_right_r, tgt_right_s;
   logic [7:0]        pend_left_r, pend_left_s, pend_right_r, pend_right_s;
   logic [7:0]        goal_left_s, goal_right_s;
   logic              pend_valid_r, pend_valid_s;
   logic [WD_W-1:0]   wd_r, wd_s;
   logic              failsafe_r, failsafe_s;
   logic              busy_r, busy_s;
   logic              accept_s;

   function automatic logic [7:0] clamp_pos(input logic [7:0] v);
      logic [7:0] r;
      if (v < MIN_C) begin
         r = MIN_C;
      end else if (v > MAX_C) begin
         r = MAX_C;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // Moves cur toward goal by at most MAX_STEP, landing exactly on goal when close.
   function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] goal);
      logic signed [8:0] diff;
      logic [7:0]        r;
      diff = $signed({1'b0, goal}) - $signed({1'b0, cur});
      if (diff > STEP_S) begin
         r = cur + STEP_C;
      end else if (diff < -STEP_S) begin
         r = cur - STEP_C;
      end else begin
         r = goal;
      end
      return r;
   endfunction

   assign frame_cnt_s   = (frame_cnt_r == LAST_CNT_C) ? '0 : frame_cnt_r + CNT_W'(1);
   assign cmd.cmd_ready = ~pend_valid_r;
   assign servo_L       = servo_left_r;
   assign servo_R       = servo_right_r;
   assign frame_tick    = frame_tick_r;
   assign failsafe      = failsafe_r;
   assign busy          = busy_r;

   // Free-running frame counter; tick is high during the last cycle of each frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_r  <= '0;
         frame_tick_r <= 1'b0;
      end else begin
         frame_cnt_r  <= frame_cnt_s;
         frame_tick_r <= (frame_cnt_s == LAST_CNT_C);
      end
   end

   // Next-state, buffer, slew and watchdog decisions.
   always_comb begin
      state_s       = state_r;
      servo_left_s  = servo_left_r;
      servo_right_s = servo_right_r;
      tgt_left_s    = tgt_left_r;
      tgt_right_s   = tgt_right_r;
      pend_left_s   = pend_left_r;
      pend_right_s  = pend_right_r;
      pend_valid_s  = pend_valid_r;
      wd_s          = wd_r;
      failsafe_s    = failsafe_r;
      accept_s      = cmd.cmd_valid && !pend_valid_r && enable && (state_r != ST_IDLE);
      goal_left_s   = pend_valid_r ? pend_left_r  : tgt_left_r;
      goal_right_s  = pend_valid_r ? pend_right_r : tgt_right_r;
      if (!enable) begin
         state_s       = ST_IDLE;
         servo_left_s  = NEUTRAL_C;
         servo_right_s = NEUTRAL_C;
         tgt_left_s    = NEUTRAL_C;
         tgt_right_s   = NEUTRAL_C;
         pend_valid_s  = 1'b0;
         failsafe_s    = 1'b0;
         wd_s          = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s       = ST_TRACK;
               servo_left_s  = NEUTRAL_C;
               servo_right_s = NEUTRAL_C;
               tgt_left_s    = NEUTRAL_C;
               tgt_right_s   = NEUTRAL_C;
               wd_s          = '0;
            end
            ST_TRACK, ST_FAILSAFE: begin
               if (frame_tick_r) begin
                  servo_left_s  = slew_step(servo_left_r, goal_left_s);
                  servo_right_s = slew_step(servo_right_r, goal_right_s);
                  tgt_left_s    = goal_left_s;
                  tgt_right_s   = goal_right_s;
                  pend_valid_s  = 1'b0;
                  wd_s          = (wd_r == WD_MAX_C) ? wd_r : wd_r + WD_W'(1);
               end else begin
                  wd_s = wd_r;
               end
               // An accept on the expiring tick keeps the drive out of failsafe.
               if (accept_s) begin
                  pend_left_s  = clamp_pos(cmd.cmd_L);
                  pend_right_s = clamp_pos(cmd.cmd_R);
                  pend_valid_s = 1'b1;
                  wd_s         = '0;
                  state_s      = ST_TRACK;
                  failsafe_s   = 1'b0;
               end else if ((state_r == ST_TRACK) && (wd_s == WD_MAX_C)) begin
                  state_s     = ST_FAILSAFE;
                  failsafe_s  = 1'b1;
                  tgt_left_s  = NEUTRAL_C;
                  tgt_right_s = NEUTRAL_C;
               end else begin
                  state_s = state_r;
               end
            end
            default: begin
               state_s = ST_IDLE;
            end
         endcase
      end
      busy_s = (servo_left_s != tgt_left_s) || (servo_right_s != tgt_right_s);
   end

   // Scheduler state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= ST_IDLE;
         servo_left_r  <= NEUTRAL_C;
         servo_right_r <= NEUTRAL_C;
         tgt_left_r    <= NEUTRAL_C;
         tgt_right_r   <= NEUTRAL_C;
         pend_left_r   <= NEUTRAL_C;
         pend_right_r  <= NEUTRAL_C;
         pend_valid_r  <= 1'b0;
         wd_r          <= '0;
         failsafe_r    <= 1'b0;
         busy_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         servo_left_r  <= servo_left_s;
         servo_right_r <= servo_right_s;
         tgt_left_r    <= tgt_left_s;
         tgt_right_r   <= tgt_right_s;
         pend_left_r   <= pend_left_s;
         pend_right_r  <= pend_right_s;
         pend_valid_r  <= pend_valid_s;
         wd_r          <= wd_s;
         failsafe_r    <= failsafe_s;
         busy_r        <= busy_s;
      end
   end
endmodule

// File: tb/tb_servo_cmd_scheduler.sv
// Scoreboard bench for servo_cmd_scheduler: per-tick servo/failsafe expectations are
// queued as commands are driven and popped on each frame_tick.
module tb_servo_cmd_scheduler;
   typedef struct packed {
      logic [7:0] l;
      logic [7:0] r;
      logic       fs;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [7:0] servo_L;
   logic [7:0] servo_R;
   logic       frame_tick;
   logic       failsafe;
   logic       busy;
   int         num_checks = 0;
   int         num_errors = 0;
   int         exp_l = 150;
   int         exp_r = 150;
   exp_t       sb_q[$];

   servo_cmd_scheduler_if cif();

   servo_cmd_scheduler #(.FRAME_CYCLES(20)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .cmd        (cif),
      .servo_L    (servo_L),
      .servo_R    (servo_R),
      .frame_tick (frame_tick),
      .failsafe   (failsafe),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      num_checks++;
      if (obs !== exp) begin
         num_errors++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int step_to(input int cur, input int goal);
      if (goal > cur + 4) return cur + 4;
      else if (goal < cur - 4) return cur - 4;
      else return goal;
   endfunction

   function automatic int clamp_pos(input int v);
      if (v < 100) return 100;
      else if (v > 200) return 200;
      else return v;
   endfunction

   task automatic push_ramp(input int gl, input int gr, input int n, input logic fs);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         exp_l = step_to(exp_l, clamp_pos(gl));
         exp_r = step_to(exp_r, clamp_pos(gr));
         e.l  = 8'(exp_l);
         e.r  = 8'(exp_r);
         e.fs = fs;
         sb_q.push_back(e);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      @(negedge clk);
      while (frame_tick !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("tick_wait", 32'(n < 40), 32'd1);
      @(posedge clk);
      #2;
   endtask

   task automatic send_cmd(input int l, input int r);
      int n;
      n = 0;
      cif.cmd_valid = 1'b1;
      cif.cmd_L     = 8'(l);
      cif.cmd_R     = 8'(r);
      @(negedge clk);
      while (cif.cmd_ready !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", 32'(n < 60), 32'd1);
      @(posedge clk);
      #2;
      cif.cmd_valid = 1'b0;
   endtask

   task automatic measure_first_tick();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (frame_tick !== 1'b1 && n < 40);
      check("first_tick_cycle", 32'(n), 32'd20);
   endtask

   // Scoreboard consumer: compare one queued expectation per frame tick.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && frame_tick === 1'b1 && sb_q.size() != 0) begin
         e = sb_q.pop_front();
         @(posedge clk);
         #1;
         check("tick_servo_L", 32'(servo_L), 32'(e.l));
         check("tick_servo_R", 32'(servo_R), 32'(e.r));
         check("tick_failsafe", 32'(failsafe), 32'(e.fs));
      end
   end

   initial begin
      rst_n         = 1'b0;
      enable        = 1'b0;
      cif.cmd_valid = 1'b0;
      cif.cmd_L     = 8'd0;
      cif.cmd_R     = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_servo_L", 32'(servo_L), 32'd150);
      check("rst_servo_R", 32'(servo_R), 32'd150);
      check("rst_tick", 32'(frame_tick), 32'd0);
      check("rst_failsafe", 32'(failsafe), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_ready", 32'(cif.cmd_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure_first_tick();

      // commands offered while disabled are ignored
      cif.cmd_valid = 1'b1;
      cif.cmd_L     = 8'd200;
      cif.cmd_R     = 8'd100;
      check("idle_ready", 32'(cif.cmd_ready), 32'd1);
      @(posedge clk);
      #2;
      cif.cmd_valid = 1'b0;
      enable        = 1'b1;
      push_ramp(150, 150, 1, 1'b0);
      wait_tick();

      // full ramp to (200,100)
      send_cmd(200, 100);
      check("ready_after_accept", 32'(cif.cmd_ready), 32'd0);
      push_ramp(200, 100, 13, 1'b0);
      wait_tick();
      check("busy_ramping", 32'(busy), 32'd1);
      repeat (12) wait_tick();
      check("busy_settled", 32'(busy), 32'd0);

      // clamping and mid-ramp reversal
      send_cmd(0, 255);
      push_ramp(0, 255, 3, 1'b0);
      repeat (3) wait_tick();
      send_cmd(255, 0);
      push_ramp(255, 0, 4, 1'b0);
      repeat (4) wait_tick();
      send_cmd(150, 150);
      push_ramp(150, 150, 13, 1'b0);
      repeat (13) wait_tick();
      check("busy_neutral", 32'(busy), 32'd0);

      // second command within a frame waits for the buffer to drain at the tick
      send_cmd(156, 144);
      check("buffer_full_ready", 32'(cif.cmd_ready), 32'd0);
      push_ramp(156, 144, 1, 1'b0);
      push_ramp(180, 120, 7, 1'b0);
      send_cmd(180, 120);
      repeat (7) wait_tick();

      // watchdog: 25th tick without an accept enters failsafe, then ramp to neutral
      push_ramp(180, 120, 17, 1'b0);
      push_ramp(180, 120, 1, 1'b1);
      push_ramp(150, 150, 8, 1'b1);
      repeat (26) wait_tick();
      check("failsafe_held", 32'(failsafe), 32'd1);
      send_cmd(160, 140);
      check("failsafe_cleared", 32'(failsafe), 32'd0);
      push_ramp(160, 140, 3, 1'b0);
      repeat (3) wait_tick();

      // enable drop mid-ramp with a pending command
      send_cmd(200, 100);
      push_ramp(200, 100, 2, 1'b0);
      repeat (2) wait_tick();
      send_cmd(190, 110);
      check("busy_before_disable", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      @(posedge clk);
      #1;
      check("dis_servo_L", 32'(servo_L), 32'd150);
      check("dis_servo_R", 32'(servo_R), 32'd150);
      check("dis_failsafe", 32'(failsafe), 32'd0);
      check("dis_busy", 32'(busy), 32'd0);
      check("dis_ready", 32'(cif.cmd_ready), 32'd1);
      exp_l = 150;
      exp_r = 150;
      repeat (3) @(posedge clk);
      #1;
      enable = 1'b1;
      push_ramp(150, 150, 2, 1'b0);
      repeat (2) wait_tick();

      // asynchronous reset in the middle of a frame
      send_cmd(200, 100);
      push_ramp(200, 100, 1, 1'b0);
      wait_tick();
      check("busy_pre_reset", 32'(busy), 32'd1);
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_servo_L", 32'(servo_L), 32'd150);
      check("arst_servo_R", 32'(servo_R), 32'd150);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_failsafe", 32'(failsafe), 32'd0);
      check("arst_tick", 32'(frame_tick), 32'd0);
      check("arst_frame_cnt", 32'(dut.frame_cnt_r), 32'd0);
      exp_l = 150;
      exp_r = 150;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      measure_first_tick();
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end
endmodule
